// File: rtl/mem_arb_pkg.sv
// Shared encodings and default sizing for the memory write-port arbiter.
// Optional boot-lock behaviour is selected in mem_arbiter by MEM_ARB_BOOT_LOCK_EN.
package mem_arb_pkg;

    localparam int DEF_N_REQ     = 3;
    localparam int DEF_MAX_BURST = 16;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_GRANT    = 2'd1,
        ARB_HANDOVER = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the search starts one past
// last_owner and wraps, so the requester nearest after the last owner wins.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] idx_s;

    // Farthest candidate first, so the nearest pending requester overwrites last
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum_s  = '0;
        idx_s  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            sum_s  = {1'b0, last_owner} + (IDX_W+1)'(i);
            idx_s  = (sum_s >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum_s - (IDX_W+1)'(N_REQ))
                                                  : IDX_W'(sum_s);
            winner = req[idx_s] ? idx_s : winner;
            valid  = valid | req[idx_s];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared byte-wide RAM write port with a dead
// HANDOVER cycle between owners. Define MEM_ARB_BOOT_LOCK_EN to hold the bus for
// requester 0 (the boot loader) until boot_done rises.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int ADDR_W    = 32,
    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] m_addr,
    input  logic [N_REQ*8-1:0]      m_data_in,
    input  logic [N_REQ-1:0]        m_write_en,
    input  logic                    boot_done,
    output logic [N_REQ-1:0]        mem_access,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [7:0]              mem_data_in,
    output logic                    mem_write_en,
    output logic [IDX_W-1:0]        arb_owner,
    output logic                    arb_busy
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] elig_s;
    logic [N_REQ-1:0] owner_onehot_s;
    logic [N_REQ-1:0] pick_onehot_s;
    logic [IDX_W-1:0] pick_s;
    logic             pick_valid_s;
    logic             others_s;
    logic             preempt_ok_s;
    logic [CNT_W-1:0] burst_inc_s;

`ifdef MEM_ARB_BOOT_LOCK_EN
    // Until boot completes only the boot loader may win; it is never preempted
    always_comb begin
        if (boot_done) begin
            elig_s = req;
        end else begin
            elig_s = req & N_REQ'(1'b1);
        end
        preempt_ok_s = (owner_q != '0);
    end
`else
    logic unused_boot_s;
    assign unused_boot_s = boot_done;

    // All requesters eligible from reset; burst preemption always applies
    always_comb begin
        elig_s       = req;
        preempt_ok_s = 1'b1;
    end
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (elig_s),
        .last_owner (last_owner_q),
        .winner     (pick_s),
        .valid      (pick_valid_s)
    );

    // Helper vectors for the owner and the arbitration winner
    always_comb begin
        owner_onehot_s = N_REQ'(1'b1) << owner_q;
        pick_onehot_s  = N_REQ'(1'b1) << pick_s;
        others_s       = |(elig_s & ~owner_onehot_s);
        burst_inc_s    = (burst_q == CNT_W'(MAX_BURST)) ? burst_q : burst_q + CNT_W'(1);
    end

    // Next-state, grant and burst-counter logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_d      = burst_q;
        grant_d      = '0;
        busy_d       = 1'b0;
        case (state_q)
            ARB_IDLE, ARB_HANDOVER: begin
                if (pick_valid_s) begin
                    state_d = ARB_GRANT;
                    owner_d = pick_s;
                    burst_d = '0;
                    grant_d = pick_onehot_s;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                // An owner release takes precedence over a coincident burst expiry
                if (!req[owner_q] ||
                    (burst_inc_s == CNT_W'(MAX_BURST) && others_s && preempt_ok_s)) begin
                    state_d      = ARB_HANDOVER;
                    last_owner_d = owner_q;
                    burst_d      = burst_inc_s;
                end else begin
                    grant_d = owner_onehot_s;
                    busy_d  = 1'b1;
                    burst_d = burst_inc_s;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Arbiter state and registered grant outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            burst_q      <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_q      <= burst_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
        end
    end

    // RAM-side mux driven directly from the registered owner
    always_comb begin
        if (busy_q) begin
            mem_addr     = m_addr[int'(owner_q)*ADDR_W +: ADDR_W];
            mem_data_in  = m_data_in[int'(owner_q)*8 +: 8];
            mem_write_en = m_write_en[owner_q];
        end else begin
            mem_addr     = '0;
            mem_data_in  = 8'h00;
            mem_write_en = 1'b0;
        end
    end

    assign mem_access = grant_q;
    assign arb_busy   = busy_q;
    assign arb_owner  = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (N_REQ=3, MAX_BURST=4).
// Boot-lock expectations follow MEM_ARB_BOOT_LOCK_EN when it is defined.
module tb_mem_arbiter;

    localparam int N      = 3;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*ADDR_W-1:0] m_addr;
    logic [N*8-1:0]    m_data_in;
    logic [N-1:0]      m_write_en;
    logic              boot_done;
    logic [N-1:0]      mem_access;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data_in;
    logic              mem_write_en;
    logic [1:0]        arb_owner;
    logic              arb_busy;

    int tests_run;
    int tests_failed;

    mem_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (4),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .m_addr       (m_addr),
        .m_data_in    (m_data_in),
        .m_write_en   (m_write_en),
        .boot_done    (boot_done),
        .mem_access   (mem_access),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .arb_owner    (arb_owner),
        .arb_busy     (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [31:0] a, input logic [7:0] d, input logic we);
        m_addr[i*ADDR_W +: ADDR_W] = a;
        m_data_in[i*8 +: 8]        = d;
        m_write_en[i]              = we;
    endtask

    task automatic chk_access(input string name, input logic [N-1:0] want);
        tests_run++;
        if (mem_access !== want) begin
            tests_failed++;
            $display("FAIL %s: mem_access=%b expected %b at %0t", name, mem_access, want, $time);
        end
    endtask

    task automatic do_reset();
        req        = '0;
        m_addr     = '0;
        m_data_in  = '0;
        m_write_en = '0;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        boot_done = 1'b1;
        do_reset();
        tests_run++;
        if ({mem_access, arb_busy, arb_owner, mem_write_en} !== 7'b0 ||
            mem_addr !== 32'h0 || mem_data_in !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: access=%b busy=%b owner=%0d we=%b addr=%h data=%h expected all 0",
                     mem_access, arb_busy, arb_owner, mem_write_en, mem_addr, mem_data_in);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_m(1, 32'h30, 8'hAB, 1'b1);
        req = 3'b010;
        chk_access("single_before_edge", 3'b000);
        tick();
        chk_access("single_grant", 3'b010);
        tests_run++;
        if (mem_addr !== 32'h30 || mem_data_in !== 8'hAB || mem_write_en !== 1'b1 ||
            arb_busy !== 1'b1 || arb_owner !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_mux: addr=%h data=%h we=%b busy=%b owner=%0d expected 30/ab/1/1/1",
                     mem_addr, mem_data_in, mem_write_en, arb_busy, arb_owner);
        end
    endtask

    task automatic test_round_robin();
        int exp_own [4] = '{0, 1, 2, 0};
        do_reset();
        req = 3'b111;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk_access("rr_grant", 3'b001 << exp_own[s]);
            end
            tick();
            chk_access("rr_handover", 3'b000);
        end
        req = '0;
    endtask

    task automatic test_no_preempt();
        do_reset();
        req = 3'b100;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk_access("solo_hold", 3'b100);
        end
        req = '0;
    endtask

    task automatic test_non_owner_write();
        do_reset();
        set_m(0, 32'h10, 8'h55, 1'b0);
        set_m(1, 32'h100, 8'h77, 1'b1);
        req = 3'b001;
        tick();
        chk_access("nonowner_grant", 3'b001);
        tests_run++;
        if (mem_write_en !== 1'b0 || mem_addr !== 32'h10 || mem_data_in !== 8'h55) begin
            tests_failed++;
            $display("FAIL nonowner_ignored: we=%b addr=%h data=%h expected 0/10/55",
                     mem_write_en, mem_addr, mem_data_in);
        end
        m_write_en[0] = 1'b1;
        #1;
        tests_run++;
        if (mem_write_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL owner_write: we=%b expected 1", mem_write_en);
        end
        req = '0;
    endtask

    task automatic test_release_expiry();
        // Release handing straight to a request arriving in the same cycle
        do_reset();
        req = 3'b001;
        tick();
        chk_access("rel_first", 3'b001);
        req = 3'b010;
        tick();
        chk_access("rel_dead_cycle", 3'b000);
        tests_run++;
        if (arb_busy !== 1'b0 || mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL rel_idle_mux: busy=%b addr=%h expected 0/0", arb_busy, mem_addr);
        end
        tick();
        chk_access("rel_next", 3'b010);
        // Owner drops on the very cycle its burst expires
        do_reset();
        req = 3'b011;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_access("exp_owner0", 3'b001);
        end
        req = 3'b010;
        tick();
        chk_access("exp_single_dead", 3'b000);
        tick();
        chk_access("exp_owner1", 3'b010);
        req = '0;
    endtask

    task automatic test_boot_lock();
        do_reset();
        boot_done = 1'b0;
        req = 3'b110;
`ifdef MEM_ARB_BOOT_LOCK_EN
        for (int k = 0; k < 20; k++) begin
            tick();
            chk_access("boot_locked", 3'b000);
        end
        boot_done = 1'b1;
        tick();
        tick();
        chk_access("boot_release", 3'b010);
`else
        tick();
        chk_access("boot_ignored", 3'b010);
        boot_done = 1'b1;
`endif
        req = '0;
        boot_done = 1'b1;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        set_m(2, 32'h200, 8'hCD, 1'b1);
        req = 3'b100;
        tick();
        tests_run++;
        if (mem_access !== 3'b100 || mem_write_en !== 1'b1 || mem_addr !== 32'h200) begin
            tests_failed++;
            $display("FAIL midrst_setup: access=%b we=%b addr=%h expected 100/1/200",
                     mem_access, mem_write_en, mem_addr);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if ({mem_access, arb_busy, arb_owner, mem_write_en} !== 7'b0 ||
            mem_addr !== 32'h0 || mem_data_in !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_outputs: access=%b busy=%b owner=%0d we=%b addr=%h data=%h expected all 0",
                     mem_access, arb_busy, arb_owner, mem_write_en, mem_addr, mem_data_in);
        end
        rst = 1'b0;
        req = 3'b101;
        tick();
        chk_access("midrst_first_is_0", 3'b001);
        req = '0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        boot_done    = 1'b1;
        req          = '0;
        m_addr       = '0;
        m_data_in    = '0;
        m_write_en   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_no_preempt();
        test_non_owner_write();
        test_release_expiry();
        test_boot_lock();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
